// File: rtl/logic_unit_serial_pkg.sv
// Shared encodings for the serial bitwise logic unit: operation select and FSM states.
package logic_unit_serial_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_serial_slice.sv
// Combinational SLICE-bit bitwise unit; one instance is time-shared across all slices.
module logic_slice
  import logic_unit_serial_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_e              op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Multicycle bitwise logic unit: processes one SLICE-bit slice per RUN cycle, start/done handshake.
module logic_unit_serial
  import logic_unit_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, acc;
  logic [WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt;
  op_e                op_q;
  logic [SLICE-1:0]   slice_y;
  logic               last;
  logic               load;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sr[SLICE-1:0]),
    .b  (b_sr[SLICE-1:0]),
    .op (op_q),
    .y  (slice_y)
  );

  assign last     = (cnt == CNT_W'(N - 1));
  assign load     = start && (state_q == IDLE || state_q == DONE);
  // Each slice result enters at the top, so after N shifts slice 0 sits in the low bits.
  assign acc_next = (acc >> SLICE) | (WIDTH'(slice_y) << (WIDTH - SLICE));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_AND;
      out  <= '0;
      zero <= 1'b0;
    end else if (load) begin
      a_sr <= in1;
      b_sr <= in2;
      op_q <= op_e'(op);
      acc  <= '0;
      cnt  <= '0;
    end else if (state_q == RUN) begin
      a_sr <= a_sr >> SLICE;
      b_sr <= b_sr >> SLICE;
      acc  <= acc_next;
      if (last) begin
        cnt  <= '0;
        out  <= acc_next;
        zero <= (acc_next == '0);
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
// Self-checking bench for logic_unit_serial: scoreboard of expected results popped on each done pulse.
module tb_logic_unit_serial;
  import logic_unit_serial_pkg::*;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             zero;
    int               acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1, in2;
  logic             busy, done, zero;
  logic [WIDTH-1:0] out;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   run_len  = 0;
  int   last_done_cyc = 0;

  logic_unit_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input op_e o, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (o)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", out, e.out);
        check("zero", zero, e.zero);
        check("latency", cyc - e.acc_cyc, N);
        check("busy_run_len", run_len, N);
        check("busy_at_done", busy, 0);
      end
    end
    run_len = busy ? run_len + 1 : 0;
  end

  // Drive a request; the next rising edge accepts it.
  task automatic issue(input op_e o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] r;
    r = model(o, a, b);
    e.out = r;
    e.zero = (r == '0);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c1, d0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    in1 = '0;
    in2 = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        check("idle_out", out, 0);
        check("idle_zero", zero, 0);
        check("idle_busy", busy, 0);
      end
    end
    check("idle_no_done", done_cnt - d0, 0);
    idle_cycle();

    // OR
    issue(OP_OR, 32'hF0F0_0000, 32'h0F0F_00FF);
    wait_done(N + 4);
    check("or_value", out, 32'hFFFF_00FF);
    idle_cycle();

    // NOR producing zero, then AND
    issue(OP_NOR, 32'hFFFF_FFFF, 32'h0);
    wait_done(N + 4);
    check("nor_zero_flag", zero, 1);
    idle_cycle();
    issue(OP_AND, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    @(negedge clk);
    check("out_held_during_run", out, 0);
    wait_done(N + 4);
    check("and_value", out, 32'h0505_0505);
    idle_cycle();

    // XOR with operand/op changes and a start pulse while busy
    issue(OP_XOR, 32'h1234_5678, 32'hFFFF_0000);
    repeat (3) @(posedge clk);
    #1;
    in1 = 32'hDEAD_BEEF;
    in2 = 32'h0BAD_F00D;
    op = OP_AND;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    in1 = 32'h1111_1111;
    op = OP_NOR;
    d0 = done_cnt;
    wait_done(N + 4);
    check("xor_value", out, 32'hEDCB_5678);
    repeat (12) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    idle_cycle();

    // Back-to-back: start held through DONE
    issue(OP_AND, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(N + 4);
    c1 = cyc;
    issue(OP_OR, 32'h1, 32'h2);
    wait_done(N + 4);
    check("b2b_spacing", cyc - c1, N + 1);
    check("b2b_value", out, 32'h0000_0003);
    idle_cycle();

    // Reset in the 4th RUN cycle aborts without a done pulse
    issue(OP_XOR, 32'hCAFE_F00D, 32'h1234_4321);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_zero", zero, 0);
    void'(sb.pop_back());
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    idle_cycle();
    issue(OP_XOR, 32'h0F0F_F0F0, 32'hFFFF_FFFF);
    wait_done(N + 4);
    check("post_reset_xor", out, 32'hF0F0_0F0F);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Multicycle bitwise logic unit for the datapath. Computes AND, OR, XOR or NOR of two WIDTH-bit operands, one SLICE-bit slice per clock.
- Exchanges operands and results with the controller over a start/done handshake.
- Sits beside the combinational 32-bit gate arrays, for area-reduced configurations. Gives identical bitwise results plus a zero flag.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH must be a multiple of SLICE.
- Derived constant N = WIDTH/SLICE, the number of RUN cycles (8 at defaults).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  operation select, sampled with start: 00 AND, 01 OR, 10 XOR, 11 NOR.
- in1  input  WIDTH  operand A, sampled with start.
- in2  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when out is valid.
- out  output  WIDTH  result register; holds its value until the next completion.
- zero  output  1  high when out == 0; updated together with out.

Behaviour:
- Reset: when rst_n=0 at an edge, state=IDLE and busy=0, done=0, out=0, zero=0. The slice counter, internal shift registers and op latch are cleared.
- Reset has priority over everything. Asserting it mid-RUN aborts the operation, gives no done pulse and leaves out=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge latches in1, in2 and op into internal shift registers, clears the counter and moves to RUN.
  - start=0 keeps the block in IDLE.
- RUN:
  - Each edge computes op on the low SLICE bits of the A and B shift registers.
  - The slice result shifts into the top of the accumulator. A and B shift right by SLICE. The counter increments.
  - Slice k (bits k*SLICE+SLICE-1 .. k*SLICE) is processed at the (k+1)th RUN edge.
  - At the edge processing slice N-1: out <= final accumulator, zero <= (final == 0), done <= 1, state -> DONE.
  - busy=1 throughout RUN. start is ignored in RUN; in1, in2 and op may change freely without effect.
- DONE (one cycle, done=1, busy=0):
  - Next edge: done <= 0.
  - If start=1, latch the new operands and go to RUN (back-to-back issue). Otherwise go to IDLE.
- Latency: start accepted at edge E gives done=1 in the cycle following edge E+N, i.e. at defaults 8 edges after acceptance.
  - Back-to-back throughput is one result per N+1 cycles.
- Width rules: all operations are purely bitwise, with no carry or sign. NOR is computed per slice as ~(a|b). out is never partially updated; intermediate slices stay internal.
- Counter width is clog2(N), and it wraps only via the RUN->DONE transition, never by overflow.

Decomposition:
- Shared package holds the op encodings (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11) and the state encodings (IDLE, RUN, DONE).
- One natural sub-module: logic_slice, a combinational SLICE-bit unit (inputs a, b, op; output y), instantiated once in the top.
- FSM, counter and shift registers live in the top.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, keep start=0 for 20 cycles -> out=0, zero=0, busy=0, done never asserts.
- OR op: in1=32'hF0F0_0000, in2=32'h0F0F_00FF, op=01, start for 1 cycle -> busy high 8 cycles, done pulse 8 edges after acceptance, out=32'hFFFF_00FF, zero=0.
- NOR/zero flag: in1=32'hFFFF_FFFF, in2=0, op=11 -> out=0, zero=1. Then AND of 32'hA5A5_A5A5 and 32'h0F0F_0F0F -> out=32'h0505_0505, zero=0.
- Operand change and start while busy: start XOR with in1=32'h1234_5678, in2=32'hFFFF_0000, then drive different in1/in2/op and pulse start during RUN -> out=32'hEDCB_5678, exactly one done pulse.
- Back-to-back: hold start=1 through DONE with a new OR (in1=1, in2=2) -> RUN re-entered without IDLE, second done 9 cycles after the first, out=32'h0000_0003.
- Reset mid-operation: assert rst_n=0 at the 4th RUN cycle -> next edge state IDLE, out=0, no done. A new XOR request afterwards completes normally.
